// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: instruction-in / decode-out handshake bundle for alu_ctrl_pipe
interface alu_ctrl_pipe_if #(parameter int CTRL_W = 5);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [4:0]        op_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] aluctrl_o;
    logic              muldiv_o;
    logic              illegal_o;
    modport slave (
        input  in_valid_i, op_i, funct3_i, funct7_i, out_ready_i,
        output in_ready_o, out_valid_o, aluctrl_o, muldiv_o, illegal_o
    );
    modport master (
        output in_valid_i, op_i, funct3_i, funct7_i, out_ready_i,
        input  in_ready_o, out_valid_o, aluctrl_o, muldiv_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: one-entry registered ALU-control decoder with valid/ready handshake.
// Define ALU_CTRL_PIPE_MULDIV_EN to decode M-extension ops and stall MULDIV_LAT cycles after each.
module alu_ctrl_pipe #(
    parameter int CTRL_W     = 5,
    parameter int MULDIV_LAT = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    alu_ctrl_pipe_if.slave bus
);
`ifdef ALU_CTRL_PIPE_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(MULDIV_LAT + 1);

    typedef enum logic [1:0] {EMPTY, FULL, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       ctrl_q, dec_ctrl;
    logic             md_q, ill_q, dec_md, dec_ill;
    logic             push, pop;

    always_comb begin
        dec_ctrl = 5'b00000;
        dec_md   = 1'b0;
        dec_ill  = 1'b0;
        case (bus.op_i)
            5'b00100, 5'b01100:
                if (bus.op_i[3] && bus.funct7_i == 7'b0000001) begin
                    dec_md   = MULDIV_EN;
                    dec_ill  = !MULDIV_EN;
                    dec_ctrl = !MULDIV_EN ? 5'b00000 :
                               bus.funct3_i == 3'b111 ? 5'b11100 : 5'd11 + 5'(bus.funct3_i);
                end else begin
                    case (bus.funct3_i)
                        3'b000:  dec_ctrl = (bus.op_i[3] && bus.funct7_i[5]) ? 5'b00000 : 5'b00001;
                        3'b001:  dec_ctrl = 5'b00010;
                        3'b010:  dec_ctrl = 5'b00011;
                        3'b011:  dec_ctrl = 5'b00100;
                        3'b100:  dec_ctrl = 5'b00101;
                        3'b101:  dec_ctrl = bus.funct7_i[5] ? 5'b00110 : 5'b00111;
                        3'b110:  dec_ctrl = 5'b01000;
                        default: dec_ctrl = 5'b01001;
                    endcase
                end
            5'b00000, 5'b01000: dec_ctrl = 5'b01010;
            5'b11000:
                case (bus.funct3_i)
                    3'b000:  dec_ctrl = 5'b10010;
                    3'b001:  dec_ctrl = 5'b10011;
                    3'b100:  dec_ctrl = 5'b10100;
                    3'b101:  dec_ctrl = 5'b10101;
                    3'b110:  dec_ctrl = 5'b10110;
                    3'b111:  dec_ctrl = 5'b10111;
                    default: dec_ill  = 1'b1;
                endcase
            5'b11011: dec_ctrl = 5'b11000;
            5'b11001: begin
                dec_ctrl = bus.funct3_i == 3'b000 ? 5'b11001 : 5'b00000;
                dec_ill  = bus.funct3_i != 3'b000;
            end
            5'b01101: dec_ctrl = 5'b11010;
            5'b00101: dec_ctrl = 5'b11011;
            default:  dec_ill  = 1'b1;
        endcase
    end

    // A held mul/div result blocks new input so it can never be overwritten before BUSY.
    assign bus.in_ready_o  = !rst_i && (state == EMPTY || (state == FULL && bus.out_ready_i && !md_q));
    assign push            = bus.in_valid_i && bus.in_ready_o;
    assign pop             = state == FULL && bus.out_ready_i;
    assign bus.out_valid_o = state == FULL;
    assign bus.aluctrl_o   = CTRL_W'(ctrl_q);
    assign bus.muldiv_o    = md_q;
    assign bus.illegal_o   = ill_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= EMPTY;
            cnt    <= '0;
            ctrl_q <= '0;
            md_q   <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            if (push) begin
                ctrl_q <= dec_ctrl;
                md_q   <= dec_md;
                ill_q  <= dec_ill;
            end
            case (state)
                EMPTY: if (push) state <= FULL;
                FULL: begin
                    if (pop && md_q) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(MULDIV_LAT - 1);
                    end else if (pop && !push) begin
                        state <= EMPTY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= EMPTY;
                    else cnt <= cnt - 1'b1;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed self-checking bench for alu_ctrl_pipe (default MULDIV_LAT=4).
// Honours ALU_CTRL_PIPE_MULDIV_EN to pick the mul/div expectations.
module tb_alu_ctrl_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_ctrl_pipe_if #(.CTRL_W(5)) bus ();
    alu_ctrl_pipe #(.CTRL_W(5), .MULDIV_LAT(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.funct3_i   = f3;
        bus.funct7_i   = f7;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid_o); end
        checks++; if (bus.aluctrl_o !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", bus.aluctrl_o); end
        checks++; if ({bus.muldiv_o, bus.illegal_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.muldiv_o, bus.illegal_o}); end
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got %b want 0", bus.in_ready_o); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", bus.in_ready_o); end
    endtask

    task automatic test_add();
        bus.out_ready_i = 1'b1;
        drive(5'b01100, 3'b000, 7'b0000000);
        tick();
        bus.in_valid_i = 1'b0;
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", bus.out_valid_o); end
        checks++; if (bus.aluctrl_o !== 5'b00001) begin errors++; $display("FAIL add_ctrl got %b want 00001", bus.aluctrl_o); end
        checks++; if ({bus.muldiv_o, bus.illegal_o} !== 2'b00) begin errors++; $display("FAIL add_flags got %b want 00", {bus.muldiv_o, bus.illegal_o}); end
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL add_pop_valid got %b want 0", bus.out_valid_o); end
        checks++; if (bus.aluctrl_o !== 5'b00001) begin errors++; $display("FAIL add_hold_ctrl got %b want 00001", bus.aluctrl_o); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops  [3] = '{5'b01100, 5'b00100, 5'b11000};
        logic [2:0] f3s  [3] = '{3'b100, 3'b101, 3'b000};
        logic [6:0] f7s  [3] = '{7'b0000000, 7'b0100000, 7'b0000000};
        logic [4:0] exps [3] = '{5'b00101, 5'b00110, 5'b10010};
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], f3s[i], f7s[i]);
            checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.in_ready_o); end
            tick();
            checks++; if ({bus.out_valid_o, bus.aluctrl_o} !== {1'b1, exps[i]}) begin errors++; $display("FAIL b2b_out[%0d] got %b want %b", i, {bus.out_valid_o, bus.aluctrl_o}, {1'b1, exps[i]}); end
        end
        bus.in_valid_i = 1'b0;
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid_o); end
    endtask

    task automatic test_stall();
        bus.out_ready_i = 1'b0;
        drive(5'b01100, 3'b110, 7'b0000000);
        tick();
        drive(5'b01100, 3'b111, 7'b0000000);
        for (int i = 0; i < 5; i++) begin
            checks++; if ({bus.out_valid_o, bus.in_ready_o, bus.aluctrl_o} !== {2'b10, 5'b01000}) begin errors++; $display("FAIL stall[%0d] valid/ready/ctrl got %b want 1001000", i, {bus.out_valid_o, bus.in_ready_o, bus.aluctrl_o}); end
            tick();
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        #1;
        checks++; if ({bus.out_valid_o, bus.in_ready_o} !== 2'b11) begin errors++; $display("FAIL stall_release got %b want 11", {bus.out_valid_o, bus.in_ready_o}); end
        tick();
        checks++; if ({bus.out_valid_o, bus.aluctrl_o} !== {1'b0, 5'b01000}) begin errors++; $display("FAIL stall_pop got %b want 001000", {bus.out_valid_o, bus.aluctrl_o}); end
    endtask

    task automatic test_decode();
        logic [4:0] ops [19] = '{5'b01100, 5'b00100, 5'b01100, 5'b00100, 5'b01100, 5'b01100, 5'b01100,
                                 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11000, 5'b11000, 5'b11011,
                                 5'b11001, 5'b11001, 5'b01101, 5'b00101, 5'b11111};
        logic [2:0] f3s [19] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b101,
                                 3'b111, 3'b010, 3'b010, 3'b001, 3'b111, 3'b011, 3'b000,
                                 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
        logic [6:0] f7s [19] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00,
                                 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        logic [5:0] exp [19] = '{6'b0_00000, 6'b0_00001, 6'b0_00010, 6'b0_00011, 6'b0_00100, 6'b0_00110, 6'b0_00111,
                                 6'b0_01001, 6'b0_01010, 6'b0_01010, 6'b0_10011, 6'b0_10111, 6'b1_00000, 6'b0_11000,
                                 6'b0_11001, 6'b1_00000, 6'b0_11010, 6'b0_11011, 6'b1_00000};
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 19; i++) begin
            drive(ops[i], f3s[i], f7s[i]);
            tick();
            checks++; if ({bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o} !== {2'b10, exp[i]}) begin errors++; $display("FAIL decode[%0d] valid/md/ill/ctrl got %b want %b", i, {bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o}, {2'b10, exp[i]}); end
        end
        bus.in_valid_i = 1'b0;
        tick();
        checks++; if ({bus.out_valid_o, bus.in_ready_o, bus.illegal_o} !== 3'b011) begin errors++; $display("FAIL decode_illegal_drain got %b want 011", {bus.out_valid_o, bus.in_ready_o, bus.illegal_o}); end
    endtask

    task automatic test_muldiv();
        bus.out_ready_i = 1'b1;
`ifdef ALU_CTRL_PIPE_MULDIV_EN
        drive(5'b01100, 3'b100, 7'b0000001);
        tick();
        bus.in_valid_i = 1'b0;
        checks++; if ({bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o} !== {3'b110, 5'b01111}) begin errors++; $display("FAIL div_out got %b want 11001111", {bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o}); end
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL div_full_ready got %b want 0", bus.in_ready_o); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.out_valid_o, bus.in_ready_o} !== 2'b00) begin errors++; $display("FAIL div_busy[%0d] got %b want 00", i, {bus.out_valid_o, bus.in_ready_o}); end
            tick();
        end
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL div_busy_end got %b want 1", bus.in_ready_o); end
        drive(5'b01100, 3'b111, 7'b0000001);
        tick();
        bus.in_valid_i = 1'b0;
        checks++; if ({bus.muldiv_o, bus.aluctrl_o} !== {1'b1, 5'b11100}) begin errors++; $display("FAIL remu_out got %b want 111100", {bus.muldiv_o, bus.aluctrl_o}); end
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL busy_rst_ready got %b want 0", bus.in_ready_o); end
        tick();
        checks++; if ({bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o} !== 8'b0) begin errors++; $display("FAIL busy_rst_out got %b want 00000000", {bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o}); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL busy_rst_after got %b want 1", bus.in_ready_o); end
`else
        drive(5'b01100, 3'b000, 7'b0000001);
        tick();
        bus.in_valid_i = 1'b0;
        checks++; if ({bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o} !== {3'b101, 5'b00000}) begin errors++; $display("FAIL mul_illegal got %b want 10100000", {bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o}); end
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL mul_ready got %b want 1", bus.in_ready_o); end
        tick();
        checks++; if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin errors++; $display("FAIL mul_no_busy got %b want 01", {bus.out_valid_o, bus.in_ready_o}); end
`endif
    endtask

    task automatic test_reset_full();
        bus.out_ready_i = 1'b0;
        drive(5'b01100, 3'b100, 7'b0000000);
        tick();
        drive(5'b01101, 3'b000, 7'b0000000);
        bus.out_ready_i = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL full_rst_ready got %b want 0", bus.in_ready_o); end
        tick();
        checks++; if ({bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o} !== 8'b0) begin errors++; $display("FAIL full_rst_out got %b want 00000000", {bus.out_valid_o, bus.muldiv_o, bus.illegal_o, bus.aluctrl_o}); end
        rst = 1'b0;
        bus.in_valid_i = 1'b0;
        tick();
        checks++; if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01) begin errors++; $display("FAIL full_rst_discard got %b want 01", {bus.out_valid_o, bus.in_ready_o}); end
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.op_i        = '0;
        bus.funct3_i    = '0;
        bus.funct7_i    = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_decode();
        test_muldiv();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 5, meaning width of aluctrl_o (legal range 5..8, codes zero-extended).
REQ-002 The block SHALL have parameter MULDIV_LAT, default 4, meaning cycles the block stays busy after a mul/div op is handed off (legal range 1..64).
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_i  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid_i  input  1  upstream presents an instruction.
REQ-006 Port: in_ready_o  output  1  block accepts the instruction this cycle.
REQ-007 Port: op_i  input  5  opcode bits [6:2].
REQ-008 Port: funct3_i  input  3  instruction funct3.
REQ-009 Port: funct7_i  input  7  instruction funct7 (bit 5 sub/sra, bit 0 M-extension).
REQ-010 Port: out_valid_o  output  1  registered decode result valid.
REQ-011 Port: out_ready_i  input  1  downstream accepts the result.
REQ-012 Port: aluctrl_o  output  CTRL_W  registered ALU control code.
REQ-013 Port: muldiv_o  output  1  held result is a mul/div op.
REQ-014 Port: illegal_o  output  1  held result is an undecodable op.

Function
REQ-015 Decode SHALL be: op 0?100 funct3 000..111 -> add 00001 (sub 00000 when op[3]&funct7[5]), sll 00010, slt 00011, sltu 00100, xor 00101, srl 00111 / sra 00110 (funct7[5]), or 01000, and 01001.
REQ-016 Decode SHALL be: op 0?000 -> 01010; op 11000 funct3 000/001/100/101/110/111 -> 10010/10011/10100/10101/10110/10111; op 11011 -> 11000; op 11001 funct3 000 -> 11001; op 01101 -> 11010; op 00101 -> 11011.
REQ-017 Any other combination (branch funct3 010/011, jalr funct3!=000, unlisted op) SHALL decode to 00000 with illegal_o=1.
REQ-018 With M-extension enabled, op 01100 with funct7=0000001 SHALL decode funct3 000..111 to 01011,01100,01101,01110,01111,10000,10001,11100 with muldiv_o=1.
REQ-019 States SHALL be EMPTY, FULL, BUSY; out_valid_o=1 only in FULL.
REQ-020 EMPTY: in_ready_o=1; in_valid_i -> capture decode, go FULL next cycle (latency 1).
REQ-021 FULL: in_ready_o = out_ready_i & ~muldiv_o; pop (out_valid_o&out_ready_i) with muldiv_o=1 -> BUSY, counter loaded MULDIV_LAT-1.
REQ-022 FULL pop with muldiv_o=0 and simultaneous push SHALL capture the new decode and stay FULL (full throughput, no bubble).
REQ-023 FULL pop with no push SHALL go EMPTY; no pop SHALL hold aluctrl_o/muldiv_o/illegal_o stable.
REQ-024 BUSY: in_ready_o=0, out_valid_o=0; counter decrements each cycle; counter==0 -> EMPTY next cycle, so BUSY lasts exactly MULDIV_LAT cycles.
REQ-025 Illegal ops SHALL pass through the handshake like any other op; they never enter BUSY.
REQ-026 Payload outputs SHALL keep their last value in EMPTY/BUSY; consumers qualify with out_valid_o.

Reset
REQ-027 rst_i high at a clock edge SHALL force EMPTY, counter 0, aluctrl_o=0, muldiv_o=0, illegal_o=0, out_valid_o=0, from any state including mid-BUSY.
REQ-028 in_ready_o SHALL be 0 while rst_i is high; handshakes in a reset cycle SHALL be discarded.

Configuration
REQ-029 Macro ALU_CTRL_PIPE_MULDIV_EN defined SHALL compile in REQ-018 decode and the BUSY state/counter.
REQ-030 Without ALU_CTRL_PIPE_MULDIV_EN, funct7=0000001 on op 01100 SHALL decode as illegal (00000, illegal_o=1), muldiv_o SHALL be tied 0, and BUSY SHALL be unreachable.

Verification
REQ-031 Reset then push add (op 01100, f3 000, f7 0) with out_ready_i=1 -> next cycle out_valid_o=1, aluctrl_o=00001, illegal_o=0.
REQ-032 Back-to-back push xor, srai(op 00100,f3 101,f7 0100000), beq, out_ready_i=1 -> outputs 00101, 00110, 10010 on three consecutive cycles, in_ready_o constant 1.
REQ-033 Push or, hold out_ready_i=0 for 5 cycles -> aluctrl_o=01000 stable, in_ready_o=0; release -> pop in one cycle.
REQ-034 MULDIV_EN, MULDIV_LAT=4: push div (f3 100, f7 0000001), pop -> muldiv_o=1, aluctrl_o=01111, then exactly 4 cycles in_ready_o=0, then in_ready_o=1.
REQ-035 Push bne-f3 010 (op 11000, f3 010) -> aluctrl_o=00000, illegal_o=1; without MULDIV_EN push mul -> illegal_o=1, no BUSY.
REQ-036 Assert rst_i during 2nd BUSY cycle -> next cycle EMPTY, all outputs 0, in_ready_o=1 after rst_i drops.
